// File: rtl/risci_mem_pkg.sv
// rtl/risci_mem_pkg.sv - shared types, size codes and arbitration decision for the memory arbiter
// Contents:
//   arb_state_t           arbiter FSM states
//   grant_t               arbitration outcome
//   LEN_B/H/W/D           memory size codes
//   *_DEFAULT             default bus widths
//   arb_pick()            combinational arbitration decision
package risci_mem_pkg;

  localparam int VLEN_DEFAULT = 64;
  localparam int DLEN_DEFAULT = 64;
  localparam int ILEN_DEFAULT = 32;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;
  localparam logic [1:0] LEN_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  // Data wins by default; fetch takes over once data has won streak-max
  // times in a row while fetch was waiting.
  function automatic grant_t arb_pick(input logic req_i, input logic req_d,
                                      input logic streak_full);
    if (req_d && !(req_i && streak_full)) return GNT_D;
    if (req_i) return GNT_I;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/risci_mem_watchdog.sv
// rtl/risci_mem_watchdog.sv - 8-bit transaction watchdog counter
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      zero the counter (takes priority over en)
//   en         count one step
//   expired    counter sits at LIMIT-1
module risci_mem_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (clear) begin
      r_cnt <= 8'd0;
    end else if (en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = (r_cnt == LAST);

endmodule

// File: rtl/risci_mem_arbiter.sv
// rtl/risci_mem_arbiter.sv - fetch/data arbiter onto one req/ack memory port
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_req/i_addr/i_flush              fetch request in
//   i_rdata/i_ack/i_err               fetch response out
//   d_req/d_we/d_addr/d_wdata/d_len   data request in
//   d_rdata/d_ack/d_err               data response out
//   m_req/m_we/m_addr/m_wdata/m_len   memory request out
//   m_rdata/m_ack                     memory response in
module risci_mem_arbiter
  import risci_mem_pkg::*;
#(
  parameter int VLEN       = VLEN_DEFAULT,
  parameter int DLEN       = DLEN_DEFAULT,
  parameter int ILEN       = ILEN_DEFAULT,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [VLEN-1:0] i_addr,
  input  logic            i_flush,
  output logic [ILEN-1:0] i_rdata,
  output logic            i_ack,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [VLEN-1:0] d_addr,
  input  logic [DLEN-1:0] d_wdata,
  input  logic [1:0]      d_len,
  output logic [DLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            d_err,
  output logic            m_req,
  output logic            m_we,
  output logic [VLEN-1:0] m_addr,
  output logic [DLEN-1:0] m_wdata,
  output logic [1:0]      m_len,
  input  logic [DLEN-1:0] m_rdata,
  input  logic            m_ack
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_FULL = SW'(STREAK_MAX);

  arb_state_t    r_state;
  logic [SW-1:0] r_streak;
  logic          r_flushed;

  grant_t w_grant;
  logic   w_grant_any;
  logic   w_busy;
  logic   w_expired;
  logic   w_i_drop;

  assign w_grant     = arb_pick(i_req, d_req, r_streak == STREAK_FULL);
  assign w_grant_any = (r_state == ST_IDLE) && (w_grant != GNT_NONE);
  assign w_busy      = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
  // A flush arriving on the completing cycle still counts.
  assign w_i_drop    = r_flushed || i_flush;

  risci_mem_watchdog #(.LIMIT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_grant_any),
    .en      (w_busy),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_streak  <= '0;
      r_flushed <= 1'b0;
      i_rdata   <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_len     <= 2'b00;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant == GNT_I) begin
            m_req    <= 1'b1;
            m_we     <= 1'b0;
            m_addr   <= i_addr;
            m_wdata  <= '0;
            m_len    <= LEN_W;
            r_streak <= '0;
            r_state  <= ST_BUSY_I;
          end else if (w_grant == GNT_D) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_len   <= d_len;
            // Streak only tracks data wins that made fetch wait.
            if (!i_req) r_streak <= '0;
            else if (r_streak != STREAK_FULL) r_streak <= r_streak + 1'b1;
            r_state <= ST_BUSY_D;
          end
        end
        ST_BUSY_I: begin
          if (i_flush) r_flushed <= 1'b1;
          if (m_ack) begin
            m_req   <= 1'b0;
            i_rdata <= m_rdata[ILEN-1:0];
            i_ack   <= !w_i_drop;
            r_state <= ST_DONE;
          end else if (w_expired) begin
            m_req   <= 1'b0;
            i_rdata <= '0;
            i_ack   <= !w_i_drop;
            i_err   <= !w_i_drop;
            r_state <= ST_DONE;
          end
        end
        ST_BUSY_D: begin
          if (m_ack) begin
            m_req   <= 1'b0;
            d_rdata <= m_we ? '0 : m_rdata;
            d_ack   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_expired) begin
            m_req   <= 1'b0;
            d_rdata <= '0;
            d_ack   <= 1'b1;
            d_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_flushed <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risci_mem_arbiter.sv
// tb/tb_risci_mem_arbiter.sv - directed self-checking bench for risci_mem_arbiter
module tb_risci_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack, i_err;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic [1:0]  d_len;
  logic [63:0] d_rdata;
  logic        d_ack, d_err;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [1:0]  m_len;
  logic [63:0] m_rdata;
  logic        m_ack;

  logic        mem_en, force_ack;
  int          mem_wait;
  int          busy_cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  logic        prev_mreq = 1'b0;
  logic [63:0] gpat = 64'd0;
  int          gcnt = 0;
  int          iack_cnt = 0;
  int          dack_cnt = 0;

  always #5 clk = ~clk;

  risci_mem_arbiter #(
    .VLEN(64), .DLEN(64), .ILEN(32), .STREAK_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_len(d_len),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_len(m_len),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  // Memory model: acks after mem_wait full BUSY cycles; force_ack injects a stray ack.
  always @(posedge clk) busy_cyc <= m_req ? busy_cyc + 1 : 0;
  assign m_ack = force_ack | (mem_en & m_req & (busy_cyc >= mem_wait));

  // Grant monitor: shifts in 1 for a fetch grant (fetch always uses 0x100 or 0x400).
  always @(negedge clk) begin
    if (m_req && !prev_mreq) begin
      gpat <= (gpat << 1) | {63'd0, (m_len == 2'b10 && !m_we && m_addr != 64'h2000)};
      gcnt <= gcnt + 1;
    end
    prev_mreq <= m_req;
    if (i_ack) iack_cnt <= iack_cnt + 1;
    if (d_ack) dack_cnt <= dack_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit sel_d, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel_d ? d_ack : i_ack) && n < max);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n, c0;
    logic bad;
    rst = 1'b1; i_req = 0; i_flush = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_len = 0;
    mem_en = 1; mem_wait = 0; force_ack = 0; m_rdata = 64'hDEADBEEF_00000013;
    repeat (3) tick();
    check_eq("reset_outs", {63'd0, |{i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
                                     m_req, m_we, m_addr, m_wdata, m_len}}, 64'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_no_req", m_req, 1'b0);

    // Single fetch, memory acks one cycle late
    mem_wait = 1;
    i_req = 1; i_addr = 64'h100;
    tick();
    check_eq("f_mreq", m_req, 1'b1);
    check_eq("f_maddr", m_addr, 64'h100);
    check_eq("f_mlen", m_len, 2'b10);
    check_eq("f_mwe", m_we, 1'b0);
    check_eq("f_mwdata", m_wdata, 64'd0);
    wait_ack(0, 20, n);
    check_eq("f_latency", 64'(n), 64'd2);
    check_eq("f_rdata", i_rdata, 32'h00000013);
    check_eq("f_err", i_err, 1'b0);
    i_req = 0;
    tick();
    check_eq("f_ack_pulse", i_ack, 1'b0);
    tick();

    // Both requesters saturating, zero-wait memory
    mem_wait = 0;
    c0 = iack_cnt;
    n = gcnt;
    i_req = 1; i_addr = 64'h100;
    d_req = 1; d_we = 0; d_addr = 64'h2000; d_len = 2'b11;
    repeat (30) tick();
    i_req = 0; d_req = 0;
    check_eq("arb_grants", 64'(gcnt - n), 64'd10);
    check_eq("arb_order", gpat & 64'h3FF, 64'h021);
    check_eq("arb_iacks", 64'(iack_cnt - c0), 64'd2);
    tick();

    // Store: m_* stable throughout BUSY
    mem_wait = 3;
    d_req = 1; d_we = 1; d_addr = 64'h2000; d_wdata = 64'h1122334455667788; d_len = 2'b11;
    tick();
    bad = 0; n = 0;
    while (!d_ack && n < 20) begin
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 64'h2000 ||
          m_wdata !== 64'h1122334455667788 || m_len !== 2'b11) bad = 1;
      tick();
      n++;
    end
    d_req = 0; d_we = 0;
    check_eq("st_stable", bad, 1'b0);
    check_eq("st_latency", 64'(n), 64'd4);
    check_eq("st_err", d_err, 1'b0);
    check_eq("st_rdata", d_rdata, 64'd0);
    tick();

    // Watchdog, TIMEOUT=8
    mem_en = 0;
    d_req = 1; d_addr = 64'h3000; d_len = 2'b10;
    tick();
    wait_ack(1, 30, n);
    d_req = 0;
    check_eq("to_latency", 64'(n), 64'd8);
    check_eq("to_err", d_err, 1'b1);
    check_eq("to_rdata", d_rdata, 64'd0);
    check_eq("to_mreq", m_req, 1'b0);
    c0 = dack_cnt;
    tick(); tick();
    force_ack = 1;
    tick();
    force_ack = 0;
    tick();
    check_eq("late_ack_quiet", {62'd0, m_req, d_err}, 64'd0);
    check_eq("late_ack_rdata", d_rdata, 64'd0);
    check_eq("late_ack_nack", 64'(dack_cnt - c0), 64'd1);

    // Flush during BUSY_I, then a normal refetch
    mem_en = 1; mem_wait = 2; m_rdata = 64'h0000_0000_0000_0093;
    c0 = iack_cnt;
    i_req = 1; i_addr = 64'h400;
    tick();
    i_flush = 1;
    tick();
    i_flush = 0;
    wait_ack(0, 30, n);
    check_eq("fl_latency", 64'(n), 64'd7);
    check_eq("fl_rdata", i_rdata, 32'h00000093);
    check_eq("fl_err", i_err, 1'b0);
    i_req = 0;
    tick();
    check_eq("fl_one_ack", 64'(iack_cnt - c0), 64'd1);
    tick();

    // Reset in BUSY_D
    mem_en = 0;
    d_req = 1; d_we = 1; d_addr = 64'h5000; d_wdata = 64'hCAFE; d_len = 2'b11;
    tick();
    check_eq("rb_busy", m_req, 1'b1);
    tick();
    c0 = dack_cnt;
    rst = 1;
    #2;
    check_eq("rb_outs_zero", {63'd0, |{i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
                                       m_req, m_we, m_addr, m_wdata, m_len}}, 64'd0);
    tick();
    rst = 0;
    mem_en = 1; mem_wait = 0;
    tick();
    check_eq("rb_regrant", m_req, 1'b1);
    check_eq("rb_addr", m_addr, 64'h5000);
    wait_ack(1, 20, n);
    d_req = 0; d_we = 0;
    check_eq("rb_latency", 64'(n), 64'd1);
    tick();
    check_eq("rb_acks", 64'(dack_cnt - c0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risci_mem_arbiter.md
# risci_mem_arbiter

Two-requester arbiter that shares one unified memory port between the core's instruction-fetch port and its data (memaccess) port. It sits between `risci_core` and the memory. It serialises transactions onto a single req/ack memory interface and applies data-priority with an anti-starvation streak limit for fetch. A per-transaction watchdog returns an error to the requester if memory never acknowledges.

## Interface
Parameters:
- `VLEN`, 64: address width.
- `DLEN`, 64: data width.
- `ILEN`, 32: instruction width.
- `STREAK_MAX`, 4: maximum consecutive data grants while fetch is waiting.
- `TIMEOUT`, 255: cycles in BUSY without `m_ack` before abort. Range 2..255.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  asynchronous, active-high reset.
- Fetch requester:
  - `i_req`  in  1  fetch request; hold until `i_ack`.
  - `i_addr`  in  VLEN  fetch address.
  - `i_flush`  in  1  discard the in-flight fetch result (branch taken).
  - `i_rdata`  out  ILEN  fetched instruction.
  - `i_ack`  out  1  one-cycle completion pulse.
  - `i_err`  out  1  valid with `i_ack`; 1 indicates timeout.
- Data requester:
  - `d_req`  in  1  data request; hold until `d_ack`.
  - `d_we`  in  1  1 selects store, 0 selects load.
  - `d_addr`  in  VLEN  data address.
  - `d_wdata`  in  DLEN  store data.
  - `d_len`  in  2  size code: 00=8, 01=16, 10=32, 11=64 bits.
  - `d_rdata`  out  DLEN  load data.
  - `d_ack`  out  1  one-cycle completion pulse.
  - `d_err`  out  1  valid with `d_ack`; 1 indicates timeout.
- Memory port:
  - `m_req`  out  1  transaction request.
  - `m_we`  out  1  write enable.
  - `m_addr`  out  VLEN  address.
  - `m_wdata`  out  DLEN  write data.
  - `m_len`  out  2  size code.
  - `m_rdata`  in  DLEN  read data; valid when `m_ack`=1.
  - `m_ack`  in  1  completion, sampled only while `m_req`=1.

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE. All outputs are registered.
- IDLE: requests are sampled on each rising edge.
  - Only one of `i_req`/`d_req` high: grant that requester.
  - Both high: grant data, unless `streak` = STREAK_MAX, in which case grant fetch.
  - On grant, latch the request into the `m_*` registers, set `m_req`=1 and go to the matching BUSY state.
- Fetch grant drives `m_we`=0, `m_len`=10, `m_wdata`=0.
- `streak` counter:
  - Increments on a data grant made while `i_req`=1.
  - Clears on any fetch grant, or on a data grant made while `i_req`=0.
  - Saturates at STREAK_MAX.
- BUSY_x, on `m_ack`=1:
  - Drop `m_req`.
  - Load `x_rdata`: `m_rdata[ILEN-1:0]` for fetch; full `m_rdata` for a data load; 0 for a store.
  - Pulse `x_ack` with `x_err`=0, then go to DONE.
- BUSY_x, watchdog: when `wdog` reaches TIMEOUT-1 with no ack, drop `m_req`, pulse `x_ack` with `x_err`=1 and `x_rdata`=0, then go to DONE.
- Flush: `i_flush`=1 on any cycle while in BUSY_I sets a sticky `flushed` flag.
  - On completion, `i_ack` is suppressed and the memory transaction still finishes normally.
  - `flushed` clears when the FSM leaves DONE.
  - `i_flush` has no effect in other states.
- DONE: one turnaround cycle. Requests are ignored, so a requester can drop `req` after seeing `ack`. Always returns to IDLE.
- `m_ack` received outside BUSY is ignored.
- `m_*` outputs hold stable for the whole BUSY period. Requester inputs are not re-sampled after the grant.

## Timing
- Reset (asynchronous): state IDLE; `streak`, `wdog` and `flushed` = 0; every output = 0.
- Reset asserted mid-transaction: `m_req` drops immediately and no ack is delivered.
- Minimum latency, request to ack:
  - Edge 1: request sampled in IDLE; `m_req` goes high.
  - Memory asserts `m_ack` combinationally in that cycle.
  - Edge 2: `x_ack` goes high for one cycle.
  - Edge 3: DONE.
  - Edge 4: next grant.
  - Back-to-back throughput is therefore one transaction every 3 cycles.
- Timeout case: `x_ack` occurs exactly TIMEOUT cycles after the edge that raised `m_req`.
- `wdog` is 8 bits wide, clears on grant, and increments on every BUSY edge.

## Structure
- Package `risci_mem_pkg`:
  - State enum `arb_state_t`.
  - Size codes `LEN_B`/`LEN_H`/`LEN_W`/`LEN_D`.
  - `VLEN`/`DLEN`/`ILEN` defaults.
- Sub-module `risci_mem_watchdog`: 8-bit counter with inputs `clear` and `en` and output `expired`. It is reused by later bus masters.
- The arbitration decision is a single combinational function of `i_req`, `d_req` and `streak`.

## Test plan
- Single fetch to `i_addr`=0x100; memory acks 1 cycle after `m_req` with `m_rdata`=0xDEADBEEF_00000013 -> `i_rdata`=0x00000013, `i_ack` pulses once, `m_len`=10, `m_we`=0.
- `i_req` and `d_req` held continuously, STREAK_MAX=4, memory acks with zero wait -> grant order D,D,D,D,I,D,D,D,D,I; `i_ack` never misses more than 4 data grants.
- Store with `d_we`=1, `d_addr`=0x2000, `d_wdata`=0x1122334455667788, `d_len`=11 -> `m_*` mirror these values for the whole BUSY period; `d_ack`=1, `d_err`=0, `d_rdata`=0.
- No `m_ack` with TIMEOUT=8 -> `d_ack`=1 and `d_err`=1 exactly 8 cycles after `m_req` rises; a late `m_ack` 2 cycles afterwards changes no output.
- `i_flush` pulsed during BUSY_I -> `i_ack` stays 0; the next fetch is granted after DONE and completes normally.
- `rst` asserted while in BUSY_D -> all outputs 0 in the same cycle; after release, a pending `d_req` is granted from IDLE.
